// File: rtl/spi_pkg.sv
// Shared SPI link definitions: FSM encoding, frame width, idle levels and bit order.
// Used by spi_master, Slave and their benches.
package spi_pkg;

  localparam int unsigned SPI_DATA_WIDTH = 8;

  localparam logic SCLK_IDLE = 1'b0;
  localparam logic CS_IDLE   = 1'b1;
  localparam logic LSB_FIRST = 1'b1;

  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] ST_SETUP = 2'd1;
  localparam logic [STATE_W-1:0] ST_SHIFT = 2'd2;
  localparam logic [STATE_W-1:0] ST_HOLD  = 2'd3;

endpackage

// File: rtl/spi_sclk_gen.sv
// Half-period counter producing the SCLK level and per-toggle strobes.
// tc_c marks the last cycle of each half-period; the strobes flag the toggle taken at the next edge.
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic toggle_en,
  output logic sclk,
  output logic tc_c,
  output logic rise_stb_c,
  output logic fall_stb_c
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tc_c       = en && (cnt_q == TERM);
  assign rise_stb_c = tc_c && toggle_en && (sclk == SCLK_IDLE);
  assign fall_stb_c = tc_c && toggle_en && (sclk != SCLK_IDLE);

  // Counter and SCLK fall back to idle whenever the link is not in a frame.
  always_ff @(posedge clk) begin
    if (reset || !en) begin
      cnt_q <= '0;
      sclk  <= SCLK_IDLE;
    end else begin
      cnt_q <= tc_c ? '0 : cnt_q + CNT_W'(1);
      if (tc_c && toggle_en) begin
        sclk <= ~sclk;
      end
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI initiator: SCLK idles low, SDO launched on SCLK rise, SDI captured on SCLK fall.
// One frame per accepted start; CS brackets SETUP, SHIFT and HOLD.
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned DATA_WIDTH = SPI_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  busy,
  output logic                  done,
  output logic                  SCLK,
  output logic                  CS,
  output logic                  SDO,
  input  logic                  SDI
);

  localparam int unsigned BIT_CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH);

  logic [STATE_W-1:0]    state_q, state_d;
  logic [DATA_WIDTH-1:0] tx_sr_q, tx_sr_d;
  logic [DATA_WIDTH-1:0] rx_sr_q, rx_sr_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic                  cs_q, cs_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  sdo_q, sdo_d;

  logic gen_en;
  logic gen_toggle_en;
  logic tc_c;
  logic rise_stb_c;
  logic fall_stb_c;
  logic sclk;

  // SETUP's terminal count is the first SCLK rise; toggling stops once all bits are in.
  assign gen_en        = (state_q != ST_IDLE);
  assign gen_toggle_en = (state_q == ST_SETUP) ||
                         ((state_q == ST_SHIFT) && (bit_cnt_q != LAST_BIT));

  spi_sclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk_gen (
    .clk        (clk),
    .reset      (reset),
    .en         (gen_en),
    .toggle_en  (gen_toggle_en),
    .sclk       (sclk),
    .tc_c       (tc_c),
    .rise_stb_c (rise_stb_c),
    .fall_stb_c (fall_stb_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      rx_data_q <= '0;
      bit_cnt_q <= '0;
      cs_q      <= CS_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sdo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      rx_data_q <= rx_data_d;
      bit_cnt_q <= bit_cnt_d;
      cs_q      <= cs_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sdo_q     <= sdo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    rx_data_d = rx_data_q;
    bit_cnt_d = bit_cnt_q;
    cs_d      = cs_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    sdo_d     = sdo_q;

    if (rise_stb_c) begin
      if (LSB_FIRST) begin
        sdo_d   = tx_sr_q[0];
        tx_sr_d = tx_sr_q >> 1;
      end else begin
        sdo_d   = tx_sr_q[DATA_WIDTH-1];
        tx_sr_d = tx_sr_q << 1;
      end
    end

    if (fall_stb_c) begin
      if (LSB_FIRST) begin
        rx_sr_d = {SDI, rx_sr_q[DATA_WIDTH-1:1]};
      end else begin
        rx_sr_d = {rx_sr_q[DATA_WIDTH-2:0], SDI};
      end
      bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_SETUP;
          tx_sr_d   = tx_data;
          rx_sr_d   = '0;
          bit_cnt_d = '0;
          cs_d      = ~CS_IDLE;
          busy_d    = 1'b1;
        end
      end
      ST_SETUP: begin
        if (tc_c) begin
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // Last fall is followed by one more low half-period before HOLD.
        if (tc_c && (bit_cnt_q == LAST_BIT)) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (tc_c) begin
          state_d   = ST_IDLE;
          cs_d      = CS_IDLE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          rx_data_d = rx_sr_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign rx_data = rx_data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign SCLK    = sclk;
  assign CS      = cs_q;
  assign SDO     = sdo_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: a CLK_DIV=2 instance against a behavioural slave and a CLK_DIV=1
// instance in SDO->SDI loopback, with randomized frames, start noise and mid-frame reset.
module tb_spi_master;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         start, start1;
  logic [W-1:0] tx_data, tx_data1;
  logic [W-1:0] rx_data, rx_data1;
  logic         busy, done, sclk, cs, sdo, sdi;
  logic         busy1, done1, sclk1, cs1, sdo1;

  int checks = 0;
  int errors = 0;
  int sel = 0;

  logic [W-1:0] slv_tx = '0;
  logic [W-1:0] slv_rx = '0;
  int           slv_idx = 0;
  logic         slv_sclk_prev = 1'b0;

  int   sdo_bad = 0;
  logic sdo_prev = 1'b0;
  logic mon_sclk_prev = 1'b0;

  spi_master #(.CLK_DIV(2), .DATA_WIDTH(W)) u_dut (
    .clk(clk), .reset(reset), .start(start), .tx_data(tx_data), .rx_data(rx_data),
    .busy(busy), .done(done), .SCLK(sclk), .CS(cs), .SDO(sdo), .SDI(sdi)
  );

  spi_master #(.CLK_DIV(1), .DATA_WIDTH(W)) u_dut_min (
    .clk(clk), .reset(reset), .start(start1), .tx_data(tx_data1), .rx_data(rx_data1),
    .busy(busy1), .done(done1), .SCLK(sclk1), .CS(cs1), .SDO(sdo1), .SDI(sdo1)
  );

  // Slave: presents its next bit after each SCLK rise, captures SDO after each fall.
  always @(negedge clk) begin
    if (cs !== 1'b0) begin
      slv_idx = 0;
      sdi = 1'b0;
    end else begin
      if (sclk && !slv_sclk_prev && slv_idx < int'(W)) sdi = slv_tx[3'(slv_idx)];
      if (!sclk && slv_sclk_prev && slv_idx < int'(W)) begin
        slv_rx[3'(slv_idx)] = sdo;
        slv_idx++;
      end
    end
    slv_sclk_prev = sclk;
  end

  // SDO may only move together with an SCLK rise (reset excepted).
  always @(negedge clk) begin
    if (!reset && (sdo !== sdo_prev) && !(sclk && !mon_sclk_prev)) sdo_bad++;
    sdo_prev = sdo;
    mon_sclk_prev = sclk;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic m_cs();   return (sel == 1) ? cs1 : cs;     endfunction
  function automatic logic m_busy(); return (sel == 1) ? busy1 : busy; endfunction
  function automatic logic m_done(); return (sel == 1) ? done1 : done; endfunction
  function automatic logic m_sclk(); return (sel == 1) ? sclk1 : sclk; endfunction
  function automatic logic [W-1:0] m_rx(); return (sel == 1) ? rx_data1 : rx_data; endfunction

  task automatic drive(input logic s, input logic [W-1:0] d);
    if (sel == 1) begin
      start1 = s;
      tx_data1 = d;
    end else begin
      start = s;
      tx_data = d;
    end
  endtask

  // One frame on the selected instance, checked against the timing rules and expected bytes.
  task automatic frame(input logic [W-1:0] tx, input logic [W-1:0] stx,
                       input bit hammer, input bit chain);
    int d, k, low, rises, first_rise, per, gaps;
    logic sp;
    logic [W-1:0] exp_rx;
    d = (sel == 1) ? 1 : 2;
    exp_rx = (sel == 1) ? tx : stx;
    slv_tx = stx;
    drive(1'b1, tx);
    @(negedge clk);
    k = 1; low = 0; rises = 0; first_rise = 0; per = 0; gaps = 0; sp = 1'b0;
    check("cs_fall", int'(m_cs()), 0);
    while (!m_done() && k < 400) begin
      if (!m_cs()) low++;
      if (!m_busy()) gaps++;
      if (m_sclk() && !sp) begin
        rises++;
        if (rises == 1) first_rise = k;
        else if (rises == 2) per = k - first_rise;
      end
      sp = m_sclk();
      if (hammer) drive(1'b1, 8'hFF);
      else drive($urandom_range(0, 3) == 0, W'($urandom));
      @(negedge clk);
      k++;
    end
    check("frame_timeout", int'(k < 400), 1);
    check("done_edge", k, (2 * int'(W) + 2) * d + 1);
    check("cs_low_cycles", low, (2 * int'(W) + 2) * d);
    check("busy_gaps", gaps, 0);
    check("sclk_rises", rises, int'(W));
    check("first_rise", first_rise, d + 1);
    check("sclk_period", per, 2 * d);
    check("cs_high_at_done", int'(m_cs()), 1);
    check("busy_low_at_done", int'(m_busy()), 0);
    check("rx_data", int'(m_rx()), int'(exp_rx));
    if (sel == 0) check("slave_rx", int'(slv_rx), int'(tx));
    if (chain) return;
    drive(1'b0, W'($urandom));
    @(negedge clk);
    check("done_width", int'(m_done()), 0);
    check("idle_cs", int'(m_cs()), 1);
    check("idle_busy", int'(m_busy()), 0);
    check("rx_hold", int'(m_rx()), int'(exp_rx));
  endtask

  initial begin
    int k, rises, dones, lows;
    logic sp;
    reset = 1'b1;
    start = 1'b0; start1 = 1'b0;
    tx_data = '0; tx_data1 = '0;
    repeat (3) @(negedge clk);
    check("rst_cs", int'(cs), 1);
    check("rst_sclk", int'(sclk), 0);
    check("rst_sdo", int'(sdo), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_rx", int'(rx_data), 0);
    check("rst_cs_min", int'(cs1), 1);
    check("rst_busy_min", int'(busy1), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    sel = 0;
    frame(8'h89, 8'h53, 1'b0, 1'b0);

    frame(8'h89, 8'h53, 1'b0, 1'b1);
    frame(8'h03, 8'h22, 1'b0, 1'b1);
    frame(8'h98, 8'h3C, 1'b0, 1'b1);
    frame(8'hC2, 8'h25, 1'b0, 1'b0);

    frame(8'h00, W'($urandom), 1'b1, 1'b0);

    for (int i = 0; i < 12; i++) begin
      frame(W'($urandom), W'($urandom), 1'b0, (i % 2) == 0);
    end

    // Abort after the third SCLK rise.
    slv_tx = 8'h5A;
    drive(1'b1, 8'h3C);
    @(negedge clk);
    drive(1'b0, 8'h00);
    k = 0; rises = 0; sp = 1'b0;
    while (rises < 3 && k < 200) begin
      if (sclk && !sp) rises++;
      sp = sclk;
      if (rises < 3) begin
        @(negedge clk);
        k++;
      end
    end
    check("rst_mid_reached", rises, 3);
    reset = 1'b1;
    @(negedge clk);
    check("abort_cs", int'(cs), 1);
    check("abort_sclk", int'(sclk), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_rx", int'(rx_data), 0);
    @(negedge clk);
    reset = 1'b0;
    dones = 0; lows = 0;
    repeat (60) begin
      @(negedge clk);
      if (done) dones++;
      if (!cs) lows++;
    end
    check("abort_no_done", dones, 0);
    check("abort_cs_idle", lows, 0);

    sel = 1;
    frame(8'hA5, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      frame(W'($urandom), 8'h00, 1'b0, (i % 2) == 0);
    end
    sel = 0;

    check("sdo_only_on_rise", sdo_bad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
